// File: rtl/bp_pkg.sv
// Shared defaults, counter encodings and FSM state type for the gshare/bimodal predictor.
package bp_pkg;

  localparam int BP_PC_W   = 16;
  localparam int BP_IDX_W  = 8;
  localparam int BP_CNT_W  = 2;
  localparam int BP_HIST_W = 8;
  localparam int BP_MODE   = 1;

  localparam logic [1:0] CNT2_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT2_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT2_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT2_STRONG_T  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_t;

  // Weakly-not-taken sits just below the taken/not-taken midpoint for any width.
  function automatic int weak_nt_value(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for one saturating up/down counter entry.
module bp_sat_counter #(
  parameter int CNT_W = bp_pkg::BP_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  output logic [CNT_W-1:0] next
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_comb begin
    next = cnt;
    if (inc) begin
      if (cnt != CNT_MAX) next = cnt + CNT_ONE;
    end else begin
      if (cnt != '0) next = cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor: counter table, global history, two-cycle lookup.
//   state   | meaning
//   ST_INIT | sweeping the table to weakly-not-taken, one entry per cycle; lookups/updates refused
//   ST_RUN  | table valid; lookups accepted every cycle, resolves update table and history
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int PC_W   = BP_PC_W,
  parameter int IDX_W  = BP_IDX_W,
  parameter int CNT_W  = BP_CNT_W,
  parameter int HIST_W = BP_HIST_W,
  parameter int MODE   = BP_MODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_rdy,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [HIST_W-1:0] ghr,
  output logic [15:0]       mispredict_cnt,
  output logic              init_done
);

  localparam int               DEPTH    = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] WEAK_NT  = CNT_W'(weak_nt_value(CNT_W));
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  bp_state_t         r_state;
  logic [IDX_W-1:0]  r_init_ptr;
  logic              r_init_done;
  logic [CNT_W-1:0]  r_table [DEPTH];
  logic [HIST_W-1:0] r_ghr;
  logic [15:0]       r_mp_cnt;
  logic              r_s1_valid;
  logic              r_s1_taken;
  logic [IDX_W-1:0]  r_s1_idx;
  logic              r_out_valid;
  logic              r_out_taken;
  logic [IDX_W-1:0]  r_out_idx;

  logic [IDX_W-1:0]  w_pc_idx;
  logic [IDX_W-1:0]  w_ghr_idx;
  logic [IDX_W-1:0]  w_lookup_idx;
  logic              w_accept;
  logic              w_upd_en;
  logic [CNT_W-1:0]  w_upd_next;
  logic [HIST_W:0]   w_ghr_shift;
  logic              w_unused_pc;

  assign w_pc_idx     = pred_pc[IDX_W+1:2];
  assign w_ghr_idx    = IDX_W'(r_ghr);
  assign w_lookup_idx = (MODE == 0) ? w_pc_idx : (w_pc_idx ^ w_ghr_idx);
  assign w_accept     = pred_valid && r_init_done;
  assign w_upd_en     = upd_valid && r_init_done;
  assign w_ghr_shift  = {r_ghr, upd_taken};
  assign w_unused_pc  = ^pred_pc;

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat (
    .cnt  (r_table[upd_idx]),
    .inc  (upd_taken),
    .next (w_upd_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_ptr <= r_init_ptr + IDX_W'(1);
          if (r_init_ptr == LAST_IDX) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_INIT;
          r_init_ptr  <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Reset is handled by the INIT sweep, so the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) begin
        r_table[r_init_ptr] <= WEAK_NT;
      end else if (w_upd_en) begin
        r_table[upd_idx] <= w_upd_next;
      end
    end
  end

  // The table is sampled at the accept edge so a same-cycle update is not visible to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr       <= '0;
      r_mp_cnt    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_taken  <= 1'b0;
      r_s1_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_taken <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      r_s1_valid  <= w_accept;
      if (w_accept) begin
        r_s1_taken <= r_table[w_lookup_idx][CNT_W-1];
        r_s1_idx   <= w_lookup_idx;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_taken <= r_s1_taken;
        r_out_idx   <= r_s1_idx;
      end
      if (w_upd_en) begin
        r_ghr <= w_ghr_shift[HIST_W-1:0];
        if ((upd_pred != upd_taken) && (r_mp_cnt != 16'hFFFF)) begin
          r_mp_cnt <= r_mp_cnt + 16'd1;
        end
      end
    end
  end

  assign pred_rdy       = r_init_done;
  assign init_done      = r_init_done;
  assign pred_out_valid = r_out_valid;
  assign pred_taken     = r_out_taken;
  assign pred_idx       = r_out_idx;
  assign ghr            = r_ghr;
  assign mispredict_cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one gshare (MODE=1) and one bimodal (MODE=0) instance driven by the same stimulus.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [15:0] pred_pc;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic        upd_taken;
  logic        upd_pred;

  logic        pred_rdy_gs, pred_out_valid_gs, pred_taken_gs, init_done_gs;
  logic [7:0]  pred_idx_gs, ghr_gs;
  logic [15:0] mp_gs;
  logic        pred_rdy_bi, pred_out_valid_bi, pred_taken_bi, init_done_bi;
  logic [7:0]  pred_idx_bi, ghr_bi;
  logic [15:0] mp_bi;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ghr_exp;

  always #5 clk = ~clk;

  branch_predictor_gshare #(.MODE(1)) u_dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_rdy(pred_rdy_gs), .pred_out_valid(pred_out_valid_gs), .pred_taken(pred_taken_gs),
    .pred_idx(pred_idx_gs), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .ghr(ghr_gs), .mispredict_cnt(mp_gs), .init_done(init_done_gs)
  );

  branch_predictor_gshare #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_rdy(pred_rdy_bi), .pred_out_valid(pred_out_valid_bi), .pred_taken(pred_taken_bi),
    .pred_idx(pred_idx_bi), .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .ghr(ghr_bi), .mispredict_cnt(mp_bi), .init_done(init_done_bi)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic [7:0] idx, input logic t, input logic p);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    upd_pred  = p;
    tick();
    upd_valid = 1'b0;
    ghr_exp   = {ghr_exp[6:0], t};
  endtask

  task automatic lookup(input string tag, input logic [15:0] pc,
                        output logic t_gs, output logic [7:0] i_gs,
                        output logic t_bi, output logic [7:0] i_bi);
    pred_valid = 1'b1;
    pred_pc    = pc;
    tick();
    pred_valid = 1'b0;
    check_eq({tag, "_early"}, {pred_out_valid_gs, pred_out_valid_bi}, 2'b00);
    tick();
    check_eq({tag, "_vld"}, {pred_out_valid_gs, pred_out_valid_bi}, 2'b11);
    t_gs = pred_taken_gs;
    i_gs = pred_idx_gs;
    t_bi = pred_taken_bi;
    i_bi = pred_idx_bi;
    tick();
    check_eq({tag, "_pulse"}, {pred_out_valid_gs, pred_out_valid_bi}, 2'b00);
  endtask

  task automatic wait_init(input string tag);
    int   cnt;
    logic saw_ov;
    cnt    = 0;
    saw_ov = 1'b0;
    while (!init_done_gs && cnt < 1000) begin
      tick();
      cnt++;
      if (pred_out_valid_gs || pred_out_valid_bi) saw_ov = 1'b1;
    end
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    check_eq({tag, "_cycles"}, cnt, 256);
    check_eq({tag, "_bi_done"}, {init_done_bi, pred_rdy_bi, pred_rdy_gs}, 3'b111);
    check_eq({tag, "_no_ov"}, saw_ov, 1'b0);
  endtask

  logic       t_gs, t_bi;
  logic [7:0] i_gs, i_bi;
  logic [7:0] exp_gs_idx;

  initial begin
    rst        = 1'b1;
    pred_valid = 1'b0;
    pred_pc    = '0;
    upd_valid  = 1'b0;
    upd_idx    = '0;
    upd_taken  = 1'b0;
    upd_pred   = 1'b0;
    ghr_exp    = '0;
    tick();
    tick();
    check_eq("rst_flags", {init_done_gs, pred_rdy_gs, pred_out_valid_gs, pred_taken_gs}, 4'b0000);
    check_eq("rst_idx_ghr_mp", {pred_idx_gs, ghr_gs, mp_gs}, 32'h0);

    // Requests and resolves held during INIT must be dropped.
    pred_valid = 1'b1;
    pred_pc    = 16'h0014;
    upd_valid  = 1'b1;
    upd_idx    = 8'h05;
    upd_taken  = 1'b1;
    upd_pred   = 1'b0;
    rst        = 1'b0;
    wait_init("init");
    tick();
    tick();
    check_eq("init_dropped_req", {pred_out_valid_gs, pred_out_valid_bi}, 2'b00);
    check_eq("init_ignored_upd", {ghr_gs, mp_gs}, 24'h0);

    lookup("lk_pc0", 16'h0000, t_gs, i_gs, t_bi, i_bi);
    check_eq("lk_pc0_taken", {t_gs, t_bi}, 2'b00);
    lookup("lk_pc14", 16'h0014, t_gs, i_gs, t_bi, i_bi);
    check_eq("lk_pc14_taken", {t_gs, t_bi}, 2'b00);
    check_eq("lk_pc14_idx", i_bi, 8'h05);
    lookup("lk_pc3fc", 16'h03FC, t_gs, i_gs, t_bi, i_bi);
    check_eq("lk_pc3fc_taken", {t_gs, t_bi}, 2'b00);
    check_eq("lk_pc3fc_idx", {i_gs, i_bi}, 16'hFFFF);

    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        pred_valid = 1'b1;
        pred_pc    = 16'h0100 + 16'(4 * i);
      end else begin
        pred_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check_eq($sformatf("b2b_vld%0d", i), {pred_out_valid_gs, pred_out_valid_bi}, 2'b11);
        check_eq($sformatf("b2b_idx%0d", i), {pred_idx_gs, pred_idx_bi}, {2{8'h40 + 8'(i - 1)}});
      end
    end
    tick();
    check_eq("b2b_end", {pred_out_valid_gs, pred_out_valid_bi}, 2'b00);

    update(8'h20, 1'b1, 1'b1);
    update(8'h20, 1'b0, 1'b0);
    update(8'h20, 1'b1, 1'b1);
    check_eq("gs_ghr", {ghr_gs, ghr_bi}, 16'h0505);
    lookup("gs_lk", 16'h0040, t_gs, i_gs, t_bi, i_bi);
    check_eq("gs_idx", i_gs, 8'h15);
    check_eq("gs_bi_idx", i_bi, 8'h10);
    check_eq("gs_taken", t_gs, 1'b0);

    for (int i = 0; i < 3; i++) update(8'h05, 1'b1, 1'b1);
    lookup("sat_t3", 16'h0014, t_gs, i_gs, t_bi, i_bi);
    check_eq("sat_t3_taken", t_bi, 1'b1);
    check_eq("sat_t3_idx", i_bi, 8'h05);
    for (int i = 0; i < 4; i++) update(8'h05, 1'b0, 1'b0);
    lookup("sat_nt4", 16'h0014, t_gs, i_gs, t_bi, i_bi);
    check_eq("sat_nt4_taken", t_bi, 1'b0);
    update(8'h05, 1'b1, 1'b1);
    lookup("sat_t1", 16'h0014, t_gs, i_gs, t_bi, i_bi);
    check_eq("sat_t1_taken", t_bi, 1'b0);
    check_eq("hist_model", ghr_gs, ghr_exp);

    // Lookup and taken update of index 3 in the same cycle.
    exp_gs_idx = 8'h03 ^ ghr_exp;
    pred_valid = 1'b1;
    pred_pc    = 16'h000C;
    upd_valid  = 1'b1;
    upd_idx    = 8'h03;
    upd_taken  = 1'b1;
    upd_pred   = 1'b1;
    tick();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    ghr_exp    = {ghr_exp[6:0], 1'b1};
    tick();
    check_eq("col_vld", {pred_out_valid_gs, pred_out_valid_bi}, 2'b11);
    check_eq("col_taken", pred_taken_bi, 1'b0);
    check_eq("col_idx", pred_idx_bi, 8'h03);
    check_eq("col_gs_old_ghr", pred_idx_gs, exp_gs_idx);
    check_eq("col_ghr", ghr_gs, ghr_exp);
    tick();
    lookup("col_next", 16'h000C, t_gs, i_gs, t_bi, i_bi);
    check_eq("col_next_taken", t_bi, 1'b1);

    check_eq("mp_zero", mp_gs, 16'd0);
    for (int i = 0; i < 3; i++) update(8'h80, 1'b1, 1'b0);
    update(8'h80, 1'b1, 1'b1);
    update(8'h80, 1'b0, 1'b0);
    check_eq("mp_three", {mp_gs, mp_bi}, {16'd3, 16'd3});

    upd_valid = 1'b1;
    upd_idx   = 8'h80;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    upd_valid = 1'b0;
    ghr_exp   = 8'hFF;
    check_eq("mp_sat", {mp_gs, mp_bi}, 32'hFFFF_FFFF);
    check_eq("mp_sat_ghr", ghr_gs, 8'hFF);
    update(8'h80, 1'b0, 1'b1);
    check_eq("mp_sat_hold", mp_gs, 16'hFFFF);
    lookup("pre_rst", 16'h0200, t_gs, i_gs, t_bi, i_bi);
    check_eq("pre_rst_taken", t_bi, 1'b1);

    // Reset lands while a lookup accepted on the previous edge is still in flight.
    pred_valid = 1'b1;
    pred_pc    = 16'h0200;
    tick();
    pred_valid = 1'b0;
    rst        = 1'b1;
    tick();
    check_eq("rr_no_ov", {pred_out_valid_gs, pred_out_valid_bi}, 2'b00);
    check_eq("rr_ghr_mp", {ghr_gs, mp_gs}, 24'h0);
    check_eq("rr_done", {init_done_gs, pred_rdy_gs}, 2'b00);
    tick();
    rst = 1'b0;
    wait_init("reinit");
    lookup("post_rst", 16'h0200, t_gs, i_gs, t_bi, i_bi);
    check_eq("post_rst_taken", {t_gs, t_bi}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
